uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares the single UART transmit user interface (tx_data/tx_valid/tx_ready) among P_NUM_REQ requesters.
- Grants one requester at a time and holds the grant for a whole message (up to the last beat), capped at a maximum burst length.
- Sits between the user-side message sources and the driver's i_user_tx_* / o_user_tx_ready ports.
- Runs on one system clock; i_tx_ready is synchronous to it.

---
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit interface among several message sources.
// A grant is held for a whole message, capped by a burst limit and revoked on idle timeout.
module uart_tx_arbiter #(
    parameter int unsigned P_NUM_REQ         = 4,
    parameter int unsigned P_UART_DATA_WIDTH = 8,
    parameter int unsigned P_MAX_BURST       = 16,
    parameter int unsigned P_IDLE_TIMEOUT    = 64,
    localparam int unsigned GrantW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [P_NUM_REQ*P_UART_DATA_WIDTH-1:0] i_req_data,
    input  logic [P_NUM_REQ-1:0]                   i_req_valid,
    input  logic [P_NUM_REQ-1:0]                   i_req_last,
    output logic [P_NUM_REQ-1:0]                   o_req_ready,
    output logic [P_UART_DATA_WIDTH-1:0]           o_tx_data,
    output logic                                   o_tx_valid,
    input  logic                                   i_tx_ready,
    output logic [GrantW-1:0]                      o_grant,
    output logic                                   o_grant_valid,
    output logic                                   o_timeout
);

    localparam int unsigned BeatW = $clog2(P_MAX_BURST) + 1;
    localparam int unsigned IdleW = $clog2(P_IDLE_TIMEOUT) + 1;
    localparam int unsigned DataW = P_UART_DATA_WIDTH;

    typedef enum logic {
        StIdle,
        StLock
    } state_e;

    state_e              state_q, state_d;
    logic [GrantW-1:0]   grant_q, grant_d;
    logic [GrantW-1:0]   ptr_q, ptr_d;
    logic [BeatW-1:0]    beat_q, beat_d;
    logic [IdleW-1:0]    idle_q, idle_d;

    logic                found;
    logic [GrantW-1:0]   pick;
    logic [GrantW-1:0]   grant_next;
    logic                valid_g;
    logic                last_g;

    // Search upward from the pointer, wrapping modulo the requester count.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
            int unsigned idx;
            idx = (int'(ptr_q) + i) % P_NUM_REQ;
            if (!found && i_req_valid[idx]) begin
                found = 1'b1;
                pick  = GrantW'(idx);
            end
        end
    end

    assign grant_next = (int'(grant_q) == P_NUM_REQ - 1) ? '0 : grant_q + 1'b1;
    assign valid_g    = i_req_valid[grant_q];
    assign last_g     = i_req_last[grant_q];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        beat_d        = beat_q;
        idle_d        = idle_q;
        o_tx_valid    = 1'b0;
        o_tx_data     = '0;
        o_req_ready   = '0;
        o_timeout     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StLock;
                    grant_d = pick;
                    beat_d  = '0;
                    idle_d  = '0;
                end
            end
            StLock: begin
                o_tx_valid           = valid_g;
                o_tx_data            = i_req_data[grant_q*DataW +: DataW];
                o_req_ready[grant_q] = i_tx_ready;
                if (valid_g && i_tx_ready) begin
                    idle_d = '0;
                    if (last_g || beat_q == BeatW'(P_MAX_BURST - 1)) begin
                        state_d = StIdle;
                        ptr_d   = grant_next;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (valid_g) begin
                    idle_d = '0;
                end else if (idle_q == IdleW'(P_IDLE_TIMEOUT - 1)) begin
                    o_timeout = 1'b1;
                    state_d   = StIdle;
                    ptr_d     = grant_next;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            idle_q  <= idle_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_grant_valid = (state_q == StLock);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-style reference model.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int MAX = 16;
    localparam int T   = 64;
    localparam int GW  = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [GW-1:0]    grant;
    logic             grant_valid;
    logic             timeout;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .P_NUM_REQ        (N),
        .P_UART_DATA_WIDTH(W),
        .P_MAX_BURST      (MAX),
        .P_IDLE_TIMEOUT   (T)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_req_data   (req_data),
        .i_req_valid  (req_valid),
        .i_req_last   (req_last),
        .o_req_ready  (req_ready),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_grant      (grant),
        .o_grant_valid(grant_valid),
        .o_timeout    (timeout)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sources: one queue of pending beats per requester.
    int unsigned  q_data[N][$];
    bit           q_last[N][$];
    logic [N-1:0] en;
    logic         rdy;

    // Reference model: owner of the channel (-1 when nobody holds it).
    int m_owner, m_ptr, m_grant, m_beats, m_idle;

    int           tout_cnt, acc_cnt;
    int           glog[$];
    int           txlog[$];
    logic         gv_prev;
    logic [W-1:0] obs_data;
    logic         obs_valid;
    logic [N-1:0] obs_ready;

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_grant = 0; m_beats = 0; m_idle = 0;
    endtask

    task automatic clear_logs();
        tout_cnt = 0; acc_cnt = 0; gv_prev = 1'b0;
        glog.delete();
        txlog.delete();
    endtask

    task automatic push_msg(input int k, input int len, input int unsigned base);
        for (int i = 0; i < len; i++) begin
            q_data[k].push_back((base + i) & 32'hFF);
            q_last[k].push_back(i == len - 1);
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            if (q_data[k].size() > 0) begin
                req_valid[k]       = en[k];
                req_data[k*W +: W] = W'(q_data[k][0]);
                req_last[k]        = q_last[k][0];
            end else begin
                req_valid[k]       = 1'b0;
                req_data[k*W +: W] = '0;
                req_last[k]        = 1'b0;
            end
        end
        tx_ready = rdy;
    endtask

    task automatic compare_outputs();
        logic         ev, et;
        logic [W-1:0] ed;
        logic [N-1:0] er;
        ev = 1'b0; et = 1'b0; ed = '0; er = '0;
        if (m_owner >= 0) begin
            ev          = req_valid[m_owner];
            ed          = req_data[m_owner*W +: W];
            er[m_owner] = tx_ready;
            et          = !req_valid[m_owner] && (m_idle == T - 1);
        end
        check("tx_valid", 32'(tx_valid), 32'(ev));
        check("tx_data", 32'(tx_data), 32'(ed));
        check("req_ready", 32'(req_ready), 32'(er));
        check("timeout", 32'(timeout), 32'(et));
        check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check("grant", 32'(grant), 32'(m_grant));
    endtask

    task automatic model_step();
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (req_valid[k]) begin
                    m_owner = k; m_grant = k; m_beats = 0; m_idle = 0;
                    break;
                end
            end
        end else if (req_valid[m_owner] && tx_ready) begin
            m_idle = 0;
            if (req_last[m_owner] || m_beats + 1 == MAX) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_beats++;
            end
        end else if (req_valid[m_owner]) begin
            m_idle = 0;
        end else if (m_idle + 1 == T) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
            m_idle++;
        end
    endtask

    // One clock cycle, starting and ending on a falling edge.
    task automatic tick();
        drive_inputs();
        #1;
        compare_outputs();
        obs_data = tx_data; obs_valid = tx_valid; obs_ready = req_ready;
        if (timeout) tout_cnt++;
        if (tx_valid && tx_ready) begin
            acc_cnt++;
            txlog.push_back(int'(tx_data));
        end
        if (grant_valid && !gv_prev) glog.push_back(int'(grant));
        gv_prev = grant_valid;
        for (int k = 0; k < N; k++) begin
            if (req_valid[k] && req_ready[k]) begin
                void'(q_data[k].pop_front());
                void'(q_last[k].pop_front());
            end
        end
        model_step();
        @(negedge clock);
    endtask

    function automatic int pending();
        int p;
        p = 0;
        for (int k = 0; k < N; k++) p += q_data[k].size();
        return p;
    endfunction

    task automatic run_drain(input string tag, input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            if (pending() == 0 && m_owner < 0 && !grant_valid) break;
            tick();
        end
        check(tag, 32'(pending()), 32'd0);
    endtask

    function automatic int log_at(input int which, input int i);
        if (which == 0) return (i < glog.size()) ? glog[i] : -1;
        return (i < txlog.size()) ? txlog[i] : -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int k = 0; k < N; k++) begin
            q_data[k].delete();
            q_last[k].delete();
        end
        en = '1; rdy = 1'b1;
        drive_inputs();
        #1;
        check_reset_outputs("rst");
        model_reset();
        clear_logs();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int stall[N];
        reset = 1'b1; req_data = '0; req_valid = '0; req_last = '0; tx_ready = 1'b0;
        en = '0; rdy = 1'b0;
        model_reset();
        clear_logs();
        #2;
        do_reset();

        // Single 3-beat message from requester 1, then the pointer sits at 2.
        push_msg(1, 3, 32'hA1);
        run_drain("t1_drain", 20);
        check("t1_grant", 32'(log_at(0, 0)), 32'd1);
        check("t1_beats", 32'(acc_cnt), 32'd3);
        check("t1_b0", 32'(log_at(1, 0)), 32'hA1);
        check("t1_b2", 32'(log_at(1, 2)), 32'hA3);
        for (int k = 0; k < N; k++) push_msg(k, 1, 32'h10 + k);
        run_drain("t1b_drain", 40);
        check("t1b_next_grant", 32'(log_at(0, 1)), 32'd2);

        // Round robin among four always-valid requesters.
        do_reset();
        for (int k = 0; k < N; k++) push_msg(k, 1, 32'h20 + k);
        push_msg(0, 1, 32'h30);
        run_drain("t2_drain", 40);
        for (int i = 0; i < 5; i++) check("t2_order", 32'(log_at(0, i)), 32'(i % N));

        // Burst cap forces release after 16 beats.
        do_reset();
        push_msg(0, 20, 32'h40);
        push_msg(1, 1, 32'hC0);
        run_drain("t3_drain", 80);
        check("t3_g0", 32'(log_at(0, 0)), 32'd0);
        check("t3_g1", 32'(log_at(0, 1)), 32'd1);
        check("t3_g2", 32'(log_at(0, 2)), 32'd0);
        check("t3_b15", 32'(log_at(1, 15)), 32'h4F);
        check("t3_b16", 32'(log_at(1, 16)), 32'hC0);
        check("t3_b17", 32'(log_at(1, 17)), 32'h50);

        // Idle timeout on requester 2.
        do_reset();
        push_msg(2, 1, 32'h77);
        en = 4'b0100;
        tick();
        en = '0;
        for (int c = 0; c < 70; c++) tick();
        check("t4_timeouts", 32'(tout_cnt), 32'd1);
        check("t4_no_beat", 32'(acc_cnt), 32'd0);
        en = '1;
        push_msg(0, 1, 32'h60);
        push_msg(3, 1, 32'h63);
        run_drain("t4_drain", 40);
        check("t4_after", 32'(log_at(0, 1)), 32'd3);

        // Backpressure mid-message.
        do_reset();
        push_msg(1, 4, 32'h50);
        for (int c = 0; c < 3; c++) tick();
        rdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t5_hold_valid", 32'(obs_valid), 32'd1);
            check("t5_hold_data", 32'(obs_data), 32'h52);
            check("t5_hold_ready", 32'(obs_ready), 32'd0);
        end
        rdy = 1'b1;
        tick();
        check("t5_resume", 32'(log_at(1, 2)), 32'h52);
        run_drain("t5_drain", 20);
        check("t5_beats", 32'(acc_cnt), 32'd4);

        // Asynchronous reset in the middle of a message.
        do_reset();
        push_msg(1, 1, 32'h11);
        run_drain("t6_pre", 20);
        push_msg(3, 6, 32'h90);
        for (int c = 0; c < 20 && acc_cnt < 3; c++) tick();
        check("t6_two_beats", 32'(acc_cnt), 32'd3);
        drive_inputs();
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        for (int k = 0; k < N; k++) begin
            q_data[k].delete();
            q_last[k].delete();
        end
        model_reset();
        clear_logs();
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < N; k++) push_msg(k, 2, 32'hE0 + 4 * k);
        run_drain("t6_drain", 60);
        check("t6_restart", 32'(log_at(0, 0)), 32'd0);

        // Randomized traffic with long source stalls and random backpressure.
        do_reset();
        for (int k = 0; k < N; k++) stall[k] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (q_data[k].size() == 0 && $urandom_range(7) == 0)
                    push_msg(k, 1 + $urandom_range(19), $urandom);
                if (stall[k] > 0) begin
                    stall[k]--;
                    en[k] = 1'b0;
                end else if ($urandom_range(199) == 0) begin
                    stall[k] = 70;
                    en[k]    = 1'b0;
                end else begin
                    en[k] = ($urandom_range(7) != 0);
                end
            end
            rdy = ($urandom_range(3) != 0);
            tick();
        end
        en = '1; rdy = 1'b1;
        run_drain("rand_drain", 400);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
